// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the multi-cycle divider.
package div_unit_pkg;

  localparam int DivDefaultWidth = 32;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] partial;
  logic           rem_top_unused;

  assign partial = {rem_i, bit_i};
  assign q_o     = (partial >= {1'b0, divisor_i});
  // A restored remainder is always below the divisor, so its top bit is zero.
  assign {rem_top_unused, rem_o} = q_o ? (partial - {1'b0, divisor_i}) : partial;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider returning {remainder, quotient} for HI/LO.
// Signed (DIV) support is built only when DIV_SIGNED_EN is defined.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DivDefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic [2*WIDTH-1:0] res_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0]   mag1_d;
  logic [WIDTH-1:0]   mag2_d;
  logic [WIDTH-1:0]   fin_quo_d;
  logic [WIDTH-1:0]   fin_rem_d;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;

`ifdef DIV_SIGNED_EN
  logic quo_neg_d, rem_neg_d;
  logic quo_neg_q, rem_neg_q;

  // Most-negative operand maps onto itself, which is its correct unsigned magnitude.
  assign mag1_d    = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign mag2_d    = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
  assign quo_neg_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
  assign rem_neg_d = signed_div_i && opdata1_i[WIDTH-1];
  assign fin_quo_d = quo_neg_q ? (~dvd_q + 1'b1) : dvd_q;
  assign fin_rem_d = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
`else
  logic signed_unused;

  assign signed_unused = signed_div_i;
  assign mag1_d        = opdata1_i;
  assign mag2_d        = opdata2_i;
  assign fin_quo_d     = dvd_q;
  assign fin_rem_d     = rem_q;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        DivFree: begin
          ready_q  <= DivResultNotReady;
          result_q <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q <= DivOn;
              dvd_q   <= mag1_d;
              dvs_q   <= mag2_d;
              rem_q   <= '0;
              cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
              quo_neg_q <= quo_neg_d;
              rem_neg_q <= rem_neg_d;
`endif
            end
          end
        end
        DivByZero: begin
          res_q   <= '0;
          state_q <= annul_i ? DivFree : DivEnd;
        end
        DivOn: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else if (cnt_q != CW'(WIDTH)) begin
            // Quotient bits shift in behind the consumed dividend bits.
            dvd_q <= {dvd_q[WIDTH-2:0], step_q};
            rem_q <= step_rem;
            cnt_q <= cnt_q + CW'(1);
          end else begin
            res_q   <= {fin_rem_d, fin_quo_d};
            state_q <= DivEnd;
          end
        end
        DivEnd: begin
          if (start_i == DivStop || annul_i) begin
            state_q  <= DivFree;
            ready_q  <= DivResultNotReady;
            result_q <= '0;
          end else begin
            ready_q  <= DivResultReady;
            result_q <= res_q;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit (WIDTH=32); honours DIV_SIGNED_EN for signed expectations.
module tb_div_unit;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp_s;
    logic [2*W-1:0] exp_u;
    int             lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Counts posedges (sampled #1 after) until ready_o, bounded.
  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!ready_o && edges < 100);
  endtask

  task automatic drop_start(input string name);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_ready_drop"}, {63'd0, ready_o}, 64'd0);
    check({name, "_result_clr"}, result_o, 64'd0);
  endtask

  task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input logic [2*W-1:0] exp, input int lat);
    int edges;
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    wait_ready(edges);
    $display("%s a=%h b=%h s=%0d result=%h ready=%0d edges=%0d", name, a, b, sgn, result_o, ready_o, edges - 1);
    check({name, "_latency"}, 64'(edges - 1), 64'(lat));
    check({name, "_result"}, result_o, exp);
    drop_start(name);
  endtask

  initial begin
    int edges;
    int rises;
    logic [2*W-1:0] held;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'h2, 32'hE},               {32'h2, 32'hE},               34};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h1, 32'h7FFFFFFC},        34};
    vecs[2]  = '{32'd7,         32'hFFFFFFFE,  1'b1, {32'h1, 32'hFFFFFFFD},        {32'h7, 32'h0},               34};
    vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h0, 32'h80000000},        {32'h80000000, 32'h0},        34};
    vecs[4]  = '{32'd5,         32'd0,         1'b0, 64'd0,                        64'd0,                        2};
    vecs[5]  = '{32'hFFFFFFFB,  32'd0,         1'b1, 64'd0,                        64'd0,                        2};
    vecs[6]  = '{32'hFFFFFFFF,  32'd1,         1'b0, {32'h0, 32'hFFFFFFFF},        {32'h0, 32'hFFFFFFFF},        34};
    vecs[7]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, {32'h0, 32'h1},               {32'h0, 32'h1},               34};
    vecs[8]  = '{32'd3,         32'd10,        1'b0, {32'h3, 32'h0},               {32'h3, 32'h0},               34};
    vecs[9]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, {32'hFFFFFFFE, 32'hE},        {32'hFFFFFF9C, 32'h0},        34};
    vecs[10] = '{32'h12345678,  32'h100,       1'b0, {32'h78, 32'h00123456},       {32'h78, 32'h00123456},       34};

    rst = 1'b0;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
              (vecs[i].sgn && SIGNED_EN) ? vecs[i].exp_s : vecs[i].exp_u, vecs[i].lat);
    end

    // Annul at iteration 10: no result, then a fresh 9/3.
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    check("annul_result", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) rises++;
    end
    $display("annul seq ready_rises=%0d", rises);
    check("annul_no_ready", 64'(rises), 64'd0);
    run_div("after_annul", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 34);

    // Annul and start together in FREE: start only counts once annul drops.
    @(negedge clk);
    opdata1_i = 32'd20; opdata2_i = 32'd4; signed_div_i = 1'b0; start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    wait_ready(edges);
    $display("annul_start seq result=%h edges=%0d", result_o, edges);
    check("annul_start_latency", 64'(edges), 64'd35);
    check("annul_start_result", result_o, {32'h0, 32'h5});
    drop_start("annul_start");

    // Operands change during ON; result must use latched values. Then END hold and annul.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opdata1_i = 32'd55; opdata2_i = 32'd0; signed_div_i = 1'b1;
    wait_ready(edges);
    $display("latched seq result=%h edges=%0d", result_o, edges);
    check("latched_latency", 64'(edges), 64'd34);
    check("latched_result", result_o, {32'h2, 32'hE});
    held = result_o;
    repeat (3) @(posedge clk);
    #1;
    check("end_hold_ready", {63'd0, ready_o}, 64'd1);
    check("end_hold_result", result_o, held);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("end_annul_ready", {63'd0, ready_o}, 64'd0);
    check("end_annul_result", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;

    // Asynchronous reset while a result is presented.
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd8; signed_div_i = 1'b0; start_i = 1'b1;
    wait_ready(edges);
    check("pre_reset_ready", {63'd0, ready_o}, 64'd1);
    #2 rst = 1'b0;
    #1;
    $display("async reset in END ready=%0d result=%h", ready_o, result_o);
    check("async_rst_ready", {63'd0, ready_o}, 64'd0);
    check("async_rst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;

    // Reset mid-iteration, then a full-latency run from clean state.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", {63'd0, ready_o}, 64'd0);
    check("mid_rst_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("after_reset", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
